// File: rtl/serial_addsub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_ctrl_if
// Description : Request/response bundle between a requesting datapath and the
//               bit-serial add/subtract controller. The master issues
//               start/sel/a/b; the slave returns busy/done/result/cout/ovf.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sel, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sel, a, b,
    output busy, done, result, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_ctrl
// Description : Bit-serial add/subtract controller. One full-adder cell is
//               stepped LSB first over WIDTH cycles to form a WIDTH-bit
//               two's-complement a+b or a-b, with a start/done handshake.
//               Optional feature macro: SERIAL_ADDSUB_OVF_EN (signed
//               overflow detection; ovf is tied low when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_ctrl_if.slave  bus
);

  localparam int                c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam logic [c_cnt_w-1:0] c_cnt_msb  = c_cnt_w'(WIDTH - 2);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_res_sh;
  logic [WIDTH-1:0]   r_result;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_sel;
  logic               r_carry;
  logic               r_busy;
  logic               r_done;
  logic               r_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic               r_c_msb_in;
  logic               r_ovf;
`endif

  logic w_y;
  logic w_s;
  logic w_cnext;

  // Single full-adder cell; subtract inverts b and the +1 comes from the
  // carry seeded with sel at start.
  assign w_y     = r_b_sh[0] ^ r_sel;
  assign w_s     = r_a_sh[0] ^ w_y ^ r_carry;
  assign w_cnext = (r_a_sh[0] & w_y) | (r_a_sh[0] & r_carry) | (w_y & r_carry);

  // Sequencer: accept in IDLE, shift one bit per RUN cycle, publish in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_res_sh   <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_sel      <= 1'b0;
      r_carry    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cout     <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      r_c_msb_in <= 1'b0;
      r_ovf      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_sel   <= bus.sel;
            r_carry <= bus.sel;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res_sh <= {w_s, r_res_sh[WIDTH-1:1]};
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_carry  <= w_cnext;
`ifdef SERIAL_ADDSUB_OVF_EN
          // Carry produced by bit WIDTH-2 is the carry into the sign bit.
          if (r_cnt == c_cnt_msb) begin
            r_c_msb_in <= w_cnext;
          end
`endif
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done   <= 1'b1;
          r_result <= r_res_sh;
          r_cout   <= r_carry;
`ifdef SERIAL_ADDSUB_OVF_EN
          r_ovf    <= r_c_msb_in ^ r_carry;
`endif
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign bus.ovf    = r_ovf;
`else
  assign bus.ovf    = 1'b0;
`endif

endmodule
`default_nettype wire
